// File: rtl/ram_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port synchronous RAM, one access in flight.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (A over B).
module ram_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              oor_q, oor_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

   logic              a_win, b_win;
   logic              win_we, win_oor;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [DATA_W-1:0] resp_data;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic prefer_b_q, prefer_b_d;

   always_comb begin
      a_win = a_req && !(b_req && prefer_b_q);
      b_win = b_req && !a_win;
   end

   // The port just granted loses the next tie.
   always_comb begin
      prefer_b_d = prefer_b_q;
      if (a_gnt) begin
         prefer_b_d = 1'b1;
      end else if (b_gnt) begin
         prefer_b_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prefer_b_q <= 1'b0;
      end else begin
         prefer_b_q <= prefer_b_d;
      end
   end
`else
   always_comb begin
      a_win = a_req;
      b_win = b_req && !a_req;
   end
`endif

   assign a_gnt = (state_q == S_IDLE) && !reset && a_win;
   assign b_gnt = (state_q == S_IDLE) && !reset && b_win;

   assign win_we    = b_gnt ? b_we    : a_we;
   assign win_addr  = b_gnt ? b_addr  : a_addr;
   assign win_wdata = b_gnt ? b_wdata : a_wdata;
   assign win_oor   = 32'(win_addr) >= DEPTH_U;

   assign resp_data = oor_q ? '0 : ram_dout;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      oor_d      = oor_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (a_gnt || b_gnt) begin
               state_d    = S_ISSUE;
               owner_d    = b_gnt;
               oor_d      = win_oor;
               ram_we_d   = win_we && !win_oor;
               ram_addr_d = win_addr;
               ram_din_d  = win_wdata;
            end
         end
         S_ISSUE: state_d = S_RESP;
         S_RESP: begin
            state_d = S_IDLE;
            if (owner_q) begin
               b_rdata_d = resp_data;
            end else begin
               a_rdata_d = resp_data;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         oor_q      <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         oor_q      <= oor_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   // A reset landing on the response cycle suppresses the ack.
   assign a_ack   = (state_q == S_RESP) && !reset && !owner_q;
   assign b_ack   = (state_q == S_RESP) && !reset && owner_q;
   assign err     = (state_q == S_RESP) && !reset && oor_q;
   assign a_rdata = a_ack ? resp_data : a_rdata_q;
   assign b_rdata = b_ack ? resp_data : b_rdata_q;

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural sync RAM, reference memory model and
// an expectation queue filled at grant time and drained at ack time.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [15:0] a_addr = '0, a_wdata = '0;
   logic        b_req = 1'b0, b_we = 1'b0;
   logic [15:0] b_addr = '0, b_wdata = '0;
   logic        a_gnt, a_ack, b_gnt, b_ack, err, ram_we;
   logic [15:0] a_rdata, b_rdata, ram_addr, ram_din;
   logic [15:0] ram_dout;

   ram_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
      .err(err), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: registered read of the pre-write word, cleared by reset.
   logic [15:0] mem [256];
   int ram_wr_cnt = 0;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         ram_dout <= 16'h0000;
      end else begin
         ram_dout <= (ram_addr < 16'd256) ? mem[ram_addr[7:0]] : 16'h0000;
         if (ram_we && ram_addr < 16'd256) begin
            mem[ram_addr[7:0]] <= ram_din;
            ram_wr_cnt <= ram_wr_cnt + 1;
         end
      end
   end

   int cyc = 0;
   int b_gnt_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0, ram_we_cnt = 0, both_gnt_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (b_gnt) b_gnt_cnt++;
      if (a_ack) a_ack_cnt++;
      if (b_ack) b_ack_cnt++;
      if (ram_we) ram_we_cnt++;
      if (a_gnt && b_gnt) both_gnt_cnt++;
   end

   typedef struct {
      bit          port;
      logic [15:0] rdata;
      bit          err;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] ref_mem [256];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic clear_model();
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      sb.delete();
   endtask

   task automatic push_exp(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata);
      exp_t e;
      e.port  = port;
      e.err   = (addr >= 16'd256);
      e.rdata = e.err ? 16'h0000 : ref_mem[addr[7:0]];
      if (we && !e.err) ref_mem[addr[7:0]] = wdata;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clear_model();
   endtask

   // Drives a request until granted (bounded); returns the grant cycle or -1.
   task automatic drive_req(input bit port, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, output int gnt_cyc);
      gnt_cyc = -1;
      if (port) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((port ? b_gnt : a_gnt) === 1'b1) begin
            gnt_cyc = cyc;
            push_exp(port, we, addr, wdata);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic wait_ack(input bit port, output int ack_cyc, output logic [15:0] rdata,
                           output logic er, output bit other);
      ack_cyc = -100;
      rdata   = 'x;
      er      = 1'bx;
      other   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ((port ? a_ack : b_ack) === 1'b1) other = 1'b1;
         if ((port ? b_ack : a_ack) === 1'b1) begin
            ack_cyc = cyc;
            rdata   = port ? b_rdata : a_rdata;
            er      = err;
            break;
         end
      end
   endtask

   task automatic run_access(input bit port, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, output int lat,
                             output logic [15:0] rdata, output logic er, output bit other,
                             output exp_t e);
      int g, a;
      drive_req(port, we, addr, wdata, g);
      wait_ack(port, a, rdata, er, other);
      lat = (g < 0) ? -1 : a - g;
      if (sb.size() > 0) begin
         e = sb.pop_front();
      end else begin
         e.port = ~port; e.rdata = 'x; e.err = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_req = 1'b1;
      b_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_a_gnt got %b want 0", a_gnt); end
      n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_b_gnt got %b want 0", b_gnt); end
      @(posedge clk);
      #1;
      a_req = 1'b0; b_req = 1'b0; reset = 1'b0;
      clear_model();
      @(negedge clk);
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
      n_checks++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL rst_ram_addr got %h want 0000", ram_addr); end
      n_checks++; if (ram_din !== 16'h0) begin n_fail++; $display("FAIL rst_ram_din got %h want 0000", ram_din); end
      n_checks++; if ({a_ack, b_ack, err} !== 3'b000) begin n_fail++; $display("FAIL rst_ack_err got %b want 000", {a_ack, b_ack, err}); end
      n_checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata got %h/%h want 0000/0000", a_rdata, b_rdata); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      int lat, we0;
      logic [15:0] rd;
      logic er;
      bit oth;
      exp_t e;
      we0 = ram_we_cnt;
      run_access(0, 1, 16'd5, 16'hBEEF, lat, rd, er, oth, e);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL wr5_latency got %0d want 2", lat); end
      n_checks++; if (ram_we_cnt - we0 != 1) begin n_fail++; $display("FAIL wr5_ram_we_cycles got %0d want 1", ram_we_cnt - we0); end
      n_checks++; if (rd !== e.rdata || er !== e.err) begin n_fail++; $display("FAIL wr5_resp got %h err %b want %h err %b", rd, er, e.rdata, e.err); end
      run_access(0, 0, 16'd5, 16'h0000, lat, rd, er, oth, e);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL rd5_latency got %0d want 2", lat); end
      n_checks++; if (rd !== e.rdata || rd !== 16'hBEEF) begin n_fail++; $display("FAIL rd5_rdata got %h want %h", rd, e.rdata); end
      n_checks++; if (er !== 1'b0 || oth) begin n_fail++; $display("FAIL rd5_err_other got err %b other %b want 0 0", er, oth); end
      @(negedge clk);
      n_checks++; if (a_rdata !== 16'hBEEF || a_ack !== 1'b0 || b_rdata !== 16'h0) begin n_fail++; $display("FAIL rd5_hold got %h ack %b b %h want beef 0 0000", a_rdata, a_ack, b_rdata); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_arbitration();
      int   ngnt, b0;
      bit   gp, want_b;
      exp_t e;
      do_reset();
      b0 = b_gnt_cnt;
      ngnt = 0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 16'd20; a_wdata = 16'h1111;
      b_req = 1'b1; b_we = 1'b0; b_addr = 16'd20; b_wdata = 16'h0000;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if ((a_gnt || b_gnt) && ngnt < 6) begin
            gp = b_gnt;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            want_b = (ngnt % 2) == 1;
`else
            want_b = 1'b0;
`endif
            n_checks++; if (gp !== want_b) begin n_fail++; $display("FAIL arb_order_%0d got %s want %s", ngnt, gp ? "B" : "A", want_b ? "B" : "A"); end
            push_exp(gp, gp ? b_we : a_we, gp ? b_addr : a_addr, gp ? b_wdata : a_wdata);
            ngnt++;
         end
         if (a_ack || b_ack) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL arb_unexpected_ack got a%b b%b want none", a_ack, b_ack);
            end else begin
               e = sb.pop_front();
               if (b_ack !== e.port || (b_ack ? b_rdata : a_rdata) !== e.rdata) begin
                  n_fail++; $display("FAIL arb_ack got port %b data %h want port %b data %h", b_ack, b_ack ? b_rdata : a_rdata, e.port, e.rdata);
               end
            end
         end
         if (ngnt == 6 && sb.size() == 0) break;
         @(posedge clk);
         #1;
         if (ngnt == 6) begin a_req = 1'b0; b_req = 1'b0; end
      end
      a_req = 1'b0; b_req = 1'b0;
      n_checks++; if (ngnt != 6 || sb.size() != 0) begin n_fail++; $display("FAIL arb_timeout got %0d grants %0d pending want 6 0", ngnt, sb.size()); end
`ifndef RAM_ARB_ROUND_ROBIN_EN
      n_checks++; if (b_gnt_cnt != b0) begin n_fail++; $display("FAIL arb_fixed_b_gnt got %0d want 0", b_gnt_cnt - b0); end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_rmw();
      int lat;
      logic [15:0] rd;
      logic er;
      bit oth;
      exp_t e;
      run_access(0, 1, 16'd9, 16'h00AA, lat, rd, er, oth, e);
      run_access(0, 1, 16'd9, 16'h00BB, lat, rd, er, oth, e);
      n_checks++; if (rd !== e.rdata || rd !== 16'h00AA) begin n_fail++; $display("FAIL rmw_old_data got %h want %h", rd, e.rdata); end
      run_access(0, 0, 16'd9, 16'h0000, lat, rd, er, oth, e);
      n_checks++; if (rd !== e.rdata || rd !== 16'h00BB) begin n_fail++; $display("FAIL rmw_new_data got %h want %h", rd, e.rdata); end
   endtask

   task automatic test_drop();
      int g, a, bg0, ba0, we0, lat;
      logic [15:0] rd;
      logic er;
      bit oth;
      exp_t e;
      bg0 = b_gnt_cnt; ba0 = b_ack_cnt; we0 = ram_we_cnt;
      drive_req(0, 0, 16'd9, 16'h0000, g);
      b_req = 1'b1; b_we = 1'b1; b_addr = 16'd9; b_wdata = 16'hFFFF;
      @(posedge clk);
      #1 b_req = 1'b0;
      wait_ack(0, a, rd, er, oth);
      e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 16'hxxxx, 1'b1};
      n_checks++; if (g < 0 || a - g != 2 || rd !== e.rdata) begin n_fail++; $display("FAIL drop_a_resp got lat %0d data %h want 2 %h", a - g, rd, e.rdata); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (b_gnt_cnt != bg0 || b_ack_cnt != ba0) begin n_fail++; $display("FAIL drop_b_activity got gnt %0d ack %0d want 0 0", b_gnt_cnt - bg0, b_ack_cnt - ba0); end
      n_checks++; if (ram_we_cnt != we0) begin n_fail++; $display("FAIL drop_ram_we got %0d want 0", ram_we_cnt - we0); end
      run_access(0, 0, 16'd9, 16'h0000, lat, rd, er, oth, e);
      n_checks++; if (rd !== 16'h00BB) begin n_fail++; $display("FAIL drop_mem_unchanged got %h want 00bb", rd); end
   endtask

   task automatic test_out_of_range();
      int lat, we0, aa0;
      logic [15:0] rd;
      logic er;
      bit oth;
      exp_t e;
      we0 = ram_we_cnt; aa0 = a_ack_cnt;
      run_access(1, 1, 16'd300, 16'h1234, lat, rd, er, oth, e);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL oor_latency got %0d want 2", lat); end
      n_checks++; if (er !== 1'b1 || er !== e.err) begin n_fail++; $display("FAIL oor_err got %b want 1", er); end
      n_checks++; if (rd !== 16'h0000 || rd !== e.rdata) begin n_fail++; $display("FAIL oor_rdata got %h want 0000", rd); end
      n_checks++; if (ram_we_cnt != we0 || a_ack_cnt != aa0 || oth) begin n_fail++; $display("FAIL oor_side_effects got we %0d a_ack %0d want 0 0", ram_we_cnt - we0, a_ack_cnt - aa0); end
   endtask

   task automatic test_boundary();
      int lat;
      logic [15:0] rd;
      logic er;
      bit oth;
      exp_t e;
      run_access(0, 1, 16'd255, 16'h5A5A, lat, rd, er, oth, e);
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL bnd_wr255_err got %b want 0", er); end
      run_access(0, 0, 16'd255, 16'h0000, lat, rd, er, oth, e);
      n_checks++; if (rd !== e.rdata || rd !== 16'h5A5A || er !== 1'b0) begin n_fail++; $display("FAIL bnd_rd255 got %h err %b want 5a5a err 0", rd, er); end
      run_access(0, 0, 16'd256, 16'h0000, lat, rd, er, oth, e);
      n_checks++; if (rd !== 16'h0000 || er !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL bnd_rd256 got %h err %b lat %0d want 0000 err 1 lat 2", rd, er, lat); end
   endtask

   task automatic test_reset_mid();
      int g, aa0, wr0, lat;
      logic [15:0] rd;
      logic er;
      bit oth;
      exp_t e;
      aa0 = a_ack_cnt; wr0 = ram_wr_cnt;
      drive_req(0, 1, 16'd7, 16'hCAFE, g);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clear_model();
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (g < 0 || a_ack_cnt != aa0) begin n_fail++; $display("FAIL rstmid_no_ack got gnt %0d acks %0d want granted 0", g, a_ack_cnt - aa0); end
      n_checks++; if (ram_wr_cnt != wr0) begin n_fail++; $display("FAIL rstmid_ram_write got %0d want 0", ram_wr_cnt - wr0); end
      run_access(0, 0, 16'd7, 16'h0000, lat, rd, er, oth, e);
      n_checks++; if (rd !== 16'h0000 || rd !== e.rdata || lat != 2) begin n_fail++; $display("FAIL rstmid_read7 got %h lat %0d want 0000 lat 2", rd, lat); end
   endtask

   initial begin
      clear_model();
      test_reset();
      test_write_read();
      test_arbitration();
      test_rmw();
      test_drop();
      test_out_of_range();
      test_boundary();
      test_reset_mid();
      n_checks++; if (both_gnt_cnt != 0) begin n_fail++; $display("FAIL gnt_onehot got %0d double grants want 0", both_gnt_cnt); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of the data words.
REQ-002 Parameter ADDR_W, default 16, width of the requester and RAM addresses.
REQ-003 Parameter DEPTH, default 256, number of implemented RAM words; valid addresses are 0..DEPTH-1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 a_req  in  1  port A (CPU) request.
REQ-007 a_we  in  1  port A write enable.
REQ-008 a_addr  in  ADDR_W  port A address.
REQ-009 a_wdata  in  DATA_W  port A write data.
REQ-010 a_gnt  out  1  port A request accepted this cycle.
REQ-011 a_ack  out  1  port A access complete; a_rdata is valid.
REQ-012 a_rdata  out  DATA_W  port A read data.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_ack, b_rdata: same widths and meaning as port A, for port B (DMA/IO).
REQ-014 err  out  1  pulses together with ack when the completed access was out of range.
REQ-015 ram_addr  out  ADDR_W  RAM address (registered).
REQ-016 ram_din  out  DATA_W  RAM write data (registered).
REQ-017 ram_we  out  1  RAM write enable (registered).
REQ-018 ram_dout  in  DATA_W  RAM read data; the RAM registers it and it is valid one clock after the address is presented.

Function
REQ-019 The FSM shall have three states: IDLE -> ISSUE -> RESP -> IDLE; it holds at most one outstanding access.
REQ-020 gnt is combinational, asserts only in IDLE, and is one-hot across ports.
REQ-021 In IDLE with any req high, the winner's we/addr/wdata shall be registered into ram_we/ram_addr/ram_din, and the FSM shall move to ISSUE.
REQ-022 In ISSUE, the RAM command shall be applied for exactly one cycle; ram_we then clears on entering RESP.
REQ-023 In RESP, the owner's ack shall be high for exactly one cycle, with rdata = ram_dout (writes included, giving the pre-write word); the non-owner's ack stays 0.
REQ-024 Latency: gnt in cycle T, ack in cycle T+2; maximum throughput is one access per 3 cycles.
REQ-025 Requesters shall hold req/we/addr/wdata stable until gnt; the arbiter samples them only in the gnt cycle.
REQ-026 If addr >= DEPTH, then ram_we = 0 for that access, ack asserts at T+2 with rdata = 0 and err = 1.
REQ-027 The rdata of a non-acked port shall be held at its last acked value.
REQ-028 A req that drops before gnt shall be ignored with no side effects.
REQ-029 ram_addr shall hold its last value in IDLE; ram_we = 0 in every state except ISSUE.

Reset
REQ-030 When reset is high at a clock edge: state = IDLE, ram_we = 0, ram_addr = 0, ram_din = 0, a/b_ack = 0, a/b_rdata = 0, err = 0, and the priority pointer = A.
REQ-031 Reset mid-access (ISSUE or RESP) shall abort the access: no ack is issued, and no RAM write occurs after the reset edge.
REQ-032 gnt shall be 0 during any cycle in which reset is high.

Configuration
REQ-033 Macro RAM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration; when both ports request, the port not granted most recently wins, and the pointer updates on every gnt.
REQ-034 Macro RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, with port A always winning over port B; no pointer register is built.

Verification
REQ-035 Reset, then A write addr 5 data 16'hBEEF, then A read addr 5 -> second ack at gnt+2 with a_rdata = 16'hBEEF, err = 0.
REQ-036 a_req and b_req held high for 6 accesses with RAM_ARB_ROUND_ROBIN_EN defined -> grant order A,B,A,B,A,B; without the macro -> A every time, b_gnt never asserts.
REQ-037 B write addr 300 data 16'h1234 with DEPTH = 256 -> ram_we stays 0, b_ack = 1 with err = 1 and b_rdata = 0 at gnt+2.
REQ-038 Assert reset during ISSUE of an A write to addr 7 -> no a_ack; a later read of addr 7 returns 16'h0000 (when the RAM is also reset).
REQ-039 A write addr 9 with 16'h00AA, then A write addr 9 with 16'h00BB -> the second ack returns a_rdata = 16'h00AA (old data), and a subsequent read returns 16'h00BB.
REQ-040 b_req pulses for 1 cycle while A holds gnt/RESP -> no b_gnt, no b_ack, RAM contents unchanged.
